// File: rtl/csr_access_arbiter.sv
// Two-requester (core ID stage, debug unit) arbiter for the single CSR port: IDLE -> ACCESS -> RESP.
// Optional macro CSR_ARB_DIFT_PROTECT_EN: core writes to 0x700/0x701 are demoted to reads and flagged with err.
module csr_access_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic [11:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [1:0]  core_op_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    input  logic        core_rready_i,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    input  logic        dbg_req_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [1:0]  dbg_op_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    input  logic        dbg_rready_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t            state_q;
    logic              owner_dbg_q;
    logic              rvalid_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              csr_access_q;
    logic [11:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        op_q;

    logic              any_req;
    logic              pick_dbg;
    logic              idle_ok;
    logic [11:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_op;
    logic              prot_hit;
    logic              owner_rready;

    always_comb begin
        any_req   = core_req_i | dbg_req_i;
        pick_dbg  = dbg_req_i & (~core_req_i | (cnt_q == LIMIT_C));
        idle_ok   = rst_n & (state_q == IDLE);
        sel_addr  = pick_dbg ? dbg_addr_i  : core_addr_i;
        sel_wdata = pick_dbg ? dbg_wdata_i : core_wdata_i;
        sel_op    = pick_dbg ? dbg_op_i    : core_op_i;
`ifdef CSR_ARB_DIFT_PROTECT_EN
        // Only core-originated modifying ops on the protected pair are demoted.
        prot_hit  = ~pick_dbg & (core_op_i != 2'b00) &
                    ((core_addr_i == 12'h700) | (core_addr_i == 12'h701));
`else
        prot_hit  = 1'b0;
`endif
        owner_rready = owner_dbg_q ? dbg_rready_i : core_rready_i;
    end

    assign core_gnt_o    = idle_ok & any_req & ~pick_dbg;
    assign dbg_gnt_o     = idle_ok & pick_dbg;
    assign core_rvalid_o = rvalid_q & ~owner_dbg_q;
    assign dbg_rvalid_o  = rvalid_q & owner_dbg_q;
    assign core_rdata_o  = owner_dbg_q ? 32'h0 : rdata_q;
    assign dbg_rdata_o   = owner_dbg_q ? rdata_q : 32'h0;
    assign core_err_o    = err_q & ~owner_dbg_q;
    assign dbg_err_o     = err_q & owner_dbg_q;
    assign csr_access_o  = csr_access_q;
    assign csr_addr_o    = addr_q;
    assign csr_wdata_o   = wdata_q;
    assign csr_op_o      = op_q;
    assign busy_o        = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_dbg_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            cnt_q        <= '0;
            csr_access_q <= 1'b0;
            addr_q       <= 12'h0;
            wdata_q      <= 32'h0;
            op_q         <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_dbg_q  <= pick_dbg;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        op_q         <= prot_hit ? 2'b00 : sel_op;
                        err_q        <= prot_hit;
                        csr_access_q <= 1'b1;
                        state_q      <= ACCESS;
                        if (pick_dbg) begin
                            cnt_q <= '0;
                        end else if (dbg_req_i && (cnt_q != LIMIT_C)) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    // Captures the pre-write value; the CSR file updates on this same edge.
                    rdata_q      <= csr_rdata_i;
                    csr_access_q <= 1'b0;
                    op_q         <= 2'b00;
                    rvalid_q     <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (owner_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: vector table, directed corner sequences, and randomized run
// against a transaction-level reference model with a shadow CSR file.
module tb_csr_access_arbiter;
    localparam int LIMIT = 4;
`ifdef CSR_ARB_DIFT_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_i = 1'b0, dbg_req_i = 1'b0;
    logic [11:0] core_addr_i = '0, dbg_addr_i = '0;
    logic [31:0] core_wdata_i = '0, dbg_wdata_i = '0;
    logic [1:0]  core_op_i = '0, dbg_op_i = '0;
    logic        core_rready_i = 1'b0, dbg_rready_i = 1'b0;
    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic        dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
    logic [31:0] core_rdata_o, dbg_rdata_o;
    logic        csr_access_o, busy_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i;
    logic [1:0]  csr_op_o;

    int n_cmp = 0;
    int n_err = 0;

    csr_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_op_i(core_op_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rready_i(core_rready_i), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_op_i(dbg_op_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rready_i(dbg_rready_i), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
        .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // CSR register file stand-in: writes whenever op != NONE, combinational read.
    bit [31:0]   mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_val = '0;

    function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] op,
                                             input logic [31:0] wd);
        case (op)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (csr_op_o != 2'b00) mem[csr_addr_o] <= apply_op(mem[csr_addr_o], csr_op_o, csr_wdata_o);
    end
    assign csr_rdata_i = mem[csr_addr_o];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(negedge clk); pre_en = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 20 && busy_o; k++) @(negedge clk);
        if (busy_o) chk({nm, "_idle_timeout"}, 32'(busy_o), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_cgnt"}, 32'(core_gnt_o), 0);   chk({nm, "_dgnt"}, 32'(dbg_gnt_o), 0);
        chk({nm, "_crv"}, 32'(core_rvalid_o), 0); chk({nm, "_drv"}, 32'(dbg_rvalid_o), 0);
        chk({nm, "_cerr"}, 32'(core_err_o), 0);   chk({nm, "_derr"}, 32'(dbg_err_o), 0);
        chk({nm, "_crd"}, core_rdata_o, 0);       chk({nm, "_drd"}, dbg_rdata_o, 0);
        chk({nm, "_acc"}, 32'(csr_access_o), 0);  chk({nm, "_op"}, 32'(csr_op_o), 0);
        chk({nm, "_addr"}, 32'(csr_addr_o), 0);   chk({nm, "_wd"}, csr_wdata_o, 0);
        chk({nm, "_busy"}, 32'(busy_o), 0);
    endtask

    typedef struct {
        logic        creq, dreq;
        logic [11:0] caddr, daddr;
        logic [1:0]  cop, dop;
        logic [31:0] cwd, dwd, pre;
        logic        exp_dbg;
        logic [1:0]  exp_op;
        logic        exp_err;
        logic [31:0] exp_mem;
    } vec_t;
    vec_t tbl [8];

    task automatic run_vec(input int i);
        vec_t        v;
        logic [11:0] wa;
        logic [31:0] wd;
        v  = tbl[i];
        wa = v.exp_dbg ? v.daddr : v.caddr;
        wd = v.exp_dbg ? v.dwd : v.cwd;
        preload(wa, v.pre);
        core_req_i = v.creq; core_addr_i = v.caddr; core_op_i = v.cop; core_wdata_i = v.cwd;
        dbg_req_i = v.dreq;  dbg_addr_i = v.daddr;  dbg_op_i = v.dop;  dbg_wdata_i = v.dwd;
        core_rready_i = 1'b1; dbg_rready_i = 1'b1;
        #1;
        chk($sformatf("v%0d_core_gnt", i), 32'(core_gnt_o), 32'(!v.exp_dbg));
        chk($sformatf("v%0d_dbg_gnt", i), 32'(dbg_gnt_o), 32'(v.exp_dbg));
        chk($sformatf("v%0d_op_c0", i), 32'(csr_op_o), 0);
        @(negedge clk); core_req_i = 1'b0; dbg_req_i = 1'b0; #1;
        chk($sformatf("v%0d_access", i), 32'(csr_access_o), 1);
        chk($sformatf("v%0d_op_c1", i), 32'(csr_op_o), 32'(v.exp_op));
        chk($sformatf("v%0d_addr", i), 32'(csr_addr_o), 32'(wa));
        chk($sformatf("v%0d_wdata", i), csr_wdata_o, wd);
        @(negedge clk); #1;
        chk($sformatf("v%0d_op_c2", i), 32'(csr_op_o), 0);
        chk($sformatf("v%0d_rv_win", i), 32'(v.exp_dbg ? dbg_rvalid_o : core_rvalid_o), 1);
        chk($sformatf("v%0d_rv_other", i), 32'(v.exp_dbg ? core_rvalid_o : dbg_rvalid_o), 0);
        chk($sformatf("v%0d_rdata", i), v.exp_dbg ? dbg_rdata_o : core_rdata_o, v.pre);
        chk($sformatf("v%0d_err", i), 32'(v.exp_dbg ? dbg_err_o : core_err_o), 32'(v.exp_err));
        @(negedge clk); #1;
        chk($sformatf("v%0d_mem", i), mem[wa], v.exp_mem);
        chk($sformatf("v%0d_busy", i), 32'(busy_o), 0);
        $display("vec %0d: %s addr=%h op=%0d issued=%0d rdata=%h err=%0b", i,
                 v.exp_dbg ? "dbg " : "core", wa, v.exp_dbg ? v.dop : v.cop, v.exp_op, v.pre, v.exp_err);
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 12'h300;
            1: return 12'h341;
            2: return 12'h700;
            3: return 12'h701;
            4: return 12'hF10;
            default: return 12'h7B0;
        endcase
    endfunction

    // Reference model: one outstanding transaction, described by its age since grant.
    int          m_age;
    int          m_lost;
    logic        m_odbg, m_err;
    logic [11:0] m_addr;
    logic [31:0] m_wd, m_rd;
    logic [1:0]  m_op;
    bit [31:0]   shadow [4096];

    initial begin
        bit          exp_d [10];
        int          g;
        logic [31:0] held;
        bit          cp, dp, dwin, prot;

        tbl[0] = '{1'b1, 1'b0, 12'h341, 12'h000, 2'b01, 2'b00, 32'h1234, 32'h0, 32'hDEAD0000,
                   1'b0, 2'b01, 1'b0, 32'h1234};
        tbl[1] = '{1'b0, 1'b1, 12'h000, 12'hF10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0BADF00D,
                   1'b1, 2'b00, 1'b0, 32'h0BADF00D};
        tbl[2] = '{1'b1, 1'b1, 12'h300, 12'h7B0, 2'b10, 2'b01, 32'h0F, 32'h77, 32'hF0,
                   1'b0, 2'b10, 1'b0, 32'hFF};
        tbl[3] = '{1'b1, 1'b1, 12'h301, 12'h7B0, 2'b11, 2'b01, 32'hFF00, 32'h77, 32'h1234FFFF,
                   1'b0, 2'b11, 1'b0, 32'h123400FF};
        tbl[4] = '{1'b0, 1'b1, 12'h000, 12'h700, 2'b00, 2'b01, 32'h0, 32'h55, 32'h11,
                   1'b1, 2'b01, 1'b0, 32'h55};
        tbl[5] = '{1'b1, 1'b0, 12'h700, 12'h000, 2'b10, 2'b00, 32'hFF, 32'h0, 32'h20,
                   1'b0, PROT ? 2'b00 : 2'b10, PROT, PROT ? 32'h20 : 32'hFF};
        tbl[6] = '{1'b1, 1'b0, 12'h701, 12'h000, 2'b00, 2'b00, 32'h0, 32'h0, 32'h33,
                   1'b0, 2'b00, 1'b0, 32'h33};
        tbl[7] = '{1'b1, 1'b0, 12'h701, 12'h000, 2'b01, 2'b00, 32'h99, 32'h0, 32'h44,
                   1'b0, PROT ? 2'b00 : 2'b01, PROT, PROT ? 32'h44 : 32'h99};

        // Reset values, with a core request held during reset.
        core_req_i = 1'b1; core_op_i = 2'b01; core_addr_i = 12'h341;
        @(negedge clk); @(negedge clk); #1;
        chk_reset_outputs("reset");
        core_req_i = 1'b0; core_op_i = 2'b00;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Starvation: both held continuously from a fresh reset.
        do_reset();
        exp_d = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        core_req_i = 1'b1; core_addr_i = 12'h300; core_op_i = 2'b00;
        dbg_req_i = 1'b1;  dbg_addr_i = 12'hF10;  dbg_op_i = 2'b00;
        core_rready_i = 1'b1; dbg_rready_i = 1'b1;
        g = 0;
        for (int cyc = 0; cyc < 60 && g < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (core_gnt_o || dbg_gnt_o) begin
                chk($sformatf("starve_grant%0d", g), 32'(dbg_gnt_o), 32'(exp_d[g]));
                chk($sformatf("starve_excl%0d", g), 32'(core_gnt_o & dbg_gnt_o), 0);
                $display("starve grant %0d -> %s", g, dbg_gnt_o ? "dbg" : "core");
                g++;
            end
        end
        if (g < 10) chk("starve_timeout", 32'(g), 10);
        @(negedge clk); core_req_i = 1'b0; dbg_req_i = 1'b0;
        wait_idle("starve");

        // Backpressure on a debug read with a core request pending.
        preload(12'hF10, 32'hCAFE0F10);
        dbg_req_i = 1'b1; dbg_addr_i = 12'hF10; dbg_op_i = 2'b00; dbg_rready_i = 1'b0;
        #1 chk("bp_dgnt", 32'(dbg_gnt_o), 1);
        @(negedge clk); dbg_req_i = 1'b0;
        core_req_i = 1'b1; core_addr_i = 12'h341; core_op_i = 2'b00; core_rready_i = 1'b1;
        #1 chk("bp_gnt_access", 32'(core_gnt_o), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_rv%0d", k), 32'(dbg_rvalid_o), 1);
            chk($sformatf("bp_rd%0d", k), dbg_rdata_o, 32'hCAFE0F10);
            chk($sformatf("bp_cgnt%0d", k), 32'(core_gnt_o), 0);
        end
        @(negedge clk); dbg_rready_i = 1'b1; #1;
        chk("bp_rv_hs", 32'(dbg_rvalid_o), 1);
        chk("bp_cgnt_hs", 32'(core_gnt_o), 0);
        @(negedge clk); #1;
        chk("bp_cgnt_after", 32'(core_gnt_o), 1);
        chk("bp_rv_after", 32'(dbg_rvalid_o), 0);
        $display("backpressure: dbg read F10 held 5 cycles, core granted after handshake");
        @(negedge clk); core_req_i = 1'b0;
        wait_idle("bp");

        // Reset during ACCESS.
        core_req_i = 1'b1; core_addr_i = 12'h341; core_op_i = 2'b01; core_wdata_i = 32'h5555;
        #1 chk("rst_mid_gnt", 32'(core_gnt_o), 1);
        @(negedge clk); core_req_i = 1'b0; #1;
        chk("rst_mid_access", 32'(csr_access_o), 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk_reset_outputs("rst_mid");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_op_after", 32'(csr_op_o), 0);
        chk("rst_mid_rv_after", 32'(core_rvalid_o), 0);
        $display("reset during ACCESS: outputs returned to reset values");

        // Randomized run against the reference model.
        do_reset();
        shadow = mem;
        m_age = -1; m_lost = 0; m_odbg = 0; m_err = 0; m_addr = '0; m_wd = '0; m_rd = '0; m_op = '0;
        cp = 0; dp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!cp) begin
                if ($urandom_range(0, 2) == 0) begin
                    cp = 1; core_addr_i = pick_addr(); core_op_i = 2'($urandom_range(0, 3));
                    core_wdata_i = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) cp = 0;
            if (!dp) begin
                if ($urandom_range(0, 2) == 0) begin
                    dp = 1; dbg_addr_i = pick_addr(); dbg_op_i = 2'($urandom_range(0, 3));
                    dbg_wdata_i = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) dp = 0;
            core_req_i = cp; dbg_req_i = dp;
            core_rready_i = 1'($urandom_range(0, 1)); dbg_rready_i = 1'($urandom_range(0, 1));
            #1;
            dwin = dbg_req_i && (!core_req_i || m_lost >= LIMIT);
            chk("rnd_cgnt", 32'(core_gnt_o), 32'(m_age < 0 && core_req_i && !dwin));
            chk("rnd_dgnt", 32'(dbg_gnt_o), 32'(m_age < 0 && dwin));
            chk("rnd_busy", 32'(busy_o), 32'(m_age >= 0));
            chk("rnd_access", 32'(csr_access_o), 32'(m_age == 0));
            chk("rnd_op", 32'(csr_op_o), 32'(m_age == 0 ? m_op : 2'b00));
            if (m_age == 0) begin
                chk("rnd_addr", 32'(csr_addr_o), 32'(m_addr));
                chk("rnd_wdata", csr_wdata_o, m_wd);
            end
            chk("rnd_crv", 32'(core_rvalid_o), 32'(m_age >= 1 && !m_odbg));
            chk("rnd_drv", 32'(dbg_rvalid_o), 32'(m_age >= 1 && m_odbg));
            if (m_age >= 1) begin
                chk("rnd_rdata", m_odbg ? dbg_rdata_o : core_rdata_o, m_rd);
                chk("rnd_err", 32'(m_odbg ? dbg_err_o : core_err_o), 32'(m_err));
            end
            if (m_age < 0) begin
                if (core_req_i || dbg_req_i) begin
                    m_odbg = dwin;
                    m_addr = dwin ? dbg_addr_i : core_addr_i;
                    m_wd   = dwin ? dbg_wdata_i : core_wdata_i;
                    prot   = PROT && !dwin && core_op_i != 2'b00 &&
                             (core_addr_i == 12'h700 || core_addr_i == 12'h701);
                    m_op   = prot ? 2'b00 : (dwin ? dbg_op_i : core_op_i);
                    m_err  = prot;
                    if (dwin) m_lost = 0;
                    else if (dbg_req_i && m_lost < LIMIT) m_lost++;
                    if (dwin) dp = 0; else cp = 0;
                    m_age = 0;
                    $display("rnd grant %s addr=%h op=%0d", dwin ? "dbg " : "core", m_addr, m_op);
                end
            end else if (m_age == 0) begin
                m_rd = shadow[m_addr];
                shadow[m_addr] = apply_op(shadow[m_addr], m_op, m_wd);
                m_age = 1;
            end else if (m_odbg ? dbg_rready_i : core_rready_i) begin
                m_age = -1;
            end
        end
        core_req_i = 1'b0; dbg_req_i = 1'b0; core_rready_i = 1'b1; dbg_rready_i = 1'b1;
        wait_idle("rnd_end");

        held = 32'(n_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, held);
        $finish;
    end
endmodule
